// File: rtl/riscv_pkg.sv
// Shared core package: register index width, data width and
// writeback source numbering used by the writeback scheduler.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_W      = 5;
   localparam int NUM_WB_SRC = 4;

   localparam int WB_SRC_ALU = 0;
   localparam int WB_SRC_MUL = 1;
   localparam int WB_SRC_DIV = 2;
   localparam int WB_SRC_LSU = 3;

   typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/riscv_wb_sched_if.sv
// Writeback request and destination-allocation handshakes.
// master = execution units / issue stage, slave = scheduler.
interface riscv_wb_sched_if
   import riscv_pkg::*;
#(
   parameter int NUM_SRC = NUM_WB_SRC
);
   logic [NUM_SRC-1:0]       req_valid_i;
   logic [REG_W*NUM_SRC-1:0] req_rd_i;
   logic [XLEN*NUM_SRC-1:0]  req_value_i;
   logic [NUM_SRC-1:0]       req_ready_o;

   logic                     alloc_valid_i;
   logic [REG_W-1:0]         alloc_rd_i;
   logic                     alloc_ready_o;

   modport master (
      output req_valid_i, req_rd_i, req_value_i,
      output alloc_valid_i, alloc_rd_i,
      input  req_ready_o, alloc_ready_o
   );

   modport slave (
      input  req_valid_i, req_rd_i, req_value_i,
      input  alloc_valid_i, alloc_rd_i,
      output req_ready_o, alloc_ready_o
   );
endinterface

// File: rtl/riscv_wb_arb.sv
// Combinational one-hot grant generator for the writeback sources.
// Ports: valid in, gnt out; with RISCV_WB_RR_EN also ptr in, gnt_idx out.
module riscv_wb_arb
   import riscv_pkg::*;
#(
   parameter int NUM_SRC = NUM_WB_SRC,
   parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] valid,
`ifdef RISCV_WB_RR_EN
   input  logic [PW-1:0]      ptr,
   output logic [PW-1:0]      gnt_idx,
`endif
   output logic [NUM_SRC-1:0] gnt
);

   // Scan sources in priority order; the first valid one wins.
   // Round-robin starts the scan at ptr, fixed priority at 0.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      found = 1'b0;
      idx   = '0;
      gnt   = '0;
`ifdef RISCV_WB_RR_EN
      gnt_idx = '0;
`endif
      for (int i = 0; i < NUM_SRC; i++) begin
`ifdef RISCV_WB_RR_EN
         idx = PW'((int'(ptr) + i) % NUM_SRC);
`else
         idx = PW'(i);
`endif
         if (!found && valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
`ifdef RISCV_WB_RR_EN
            gnt_idx  = idx;
`endif
         end
      end
   end

endmodule

// File: rtl/riscv_wb_sched.sv
// Writeback scheduler: arbitrates unit results onto one registered
// regfile write port and tracks pending destinations for hazards.
// Ports: clk_i, rst_i (sync, active-low), bus (requests + alloc),
// ra_i/rb_i -> ra_busy_o/rb_busy_o, wr_rd_o/wr_value_o to regfile.
// Macro RISCV_WB_RR_EN selects round-robin instead of fixed priority.
module riscv_wb_sched
   import riscv_pkg::*;
#(
   parameter int NUM_SRC = NUM_WB_SRC
) (
   input  logic             clk_i,
   input  logic             rst_i,
   riscv_wb_sched_if.slave  bus,
   input  logic [REG_W-1:0] ra_i,
   input  logic [REG_W-1:0] rb_i,
   output logic             ra_busy_o,
   output logic             rb_busy_o,
   output logic [REG_W-1:0] wr_rd_o,
   output logic [XLEN-1:0]  wr_value_o
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] gnt;
   logic               gnt_any;
   reg_idx_t           sel_rd;
   logic [XLEN-1:0]    sel_value;

   logic [31:0]        pending;
   logic [31:0]        pend_nxt;
   logic [31:0]        set_vec;
   logic [31:0]        clr_vec;
   logic               alloc_ok;

`ifdef RISCV_WB_RR_EN
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gnt_idx;

   riscv_wb_arb #(
      .NUM_SRC (NUM_SRC),
      .PW      (PW)
   ) u_arb (
      .valid   (bus.req_valid_i),
      .ptr     (ptr),
      .gnt_idx (gnt_idx),
      .gnt     (gnt)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ptr <= '0;
      end else if (gnt_any) begin
         if (gnt_idx == PW'(NUM_SRC - 1))
            ptr <= '0;
         else
            ptr <= gnt_idx + PW'(1);
      end
   end
`else
   riscv_wb_arb #(
      .NUM_SRC (NUM_SRC),
      .PW      (PW)
   ) u_arb (
      .valid   (bus.req_valid_i),
      .gnt     (gnt)
   );
`endif

   assign bus.req_ready_o = gnt;
   assign gnt_any         = |gnt;

   // One-hot grant, so the last match is the only match.
   always_comb begin
      sel_rd    = '0;
      sel_value = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (gnt[k]) begin
            sel_rd    = bus.req_rd_i[REG_W*k +: REG_W];
            sel_value = bus.req_value_i[XLEN*k +: XLEN];
         end
      end
   end

   assign alloc_ok = bus.alloc_valid_i &&
                     ((bus.alloc_rd_i == '0) ||
                      !pending[bus.alloc_rd_i]);
   assign bus.alloc_ready_o = alloc_ok;

   // A new reservation overrides a retiring write to the same reg.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (alloc_ok && (bus.alloc_rd_i != '0))
         set_vec[bus.alloc_rd_i] = 1'b1;
      if (wr_rd_o != '0)
         clr_vec[wr_rd_o] = 1'b1;
      pend_nxt    = (pending & ~clr_vec) | set_vec;
      pend_nxt[0] = 1'b0;
   end

   // pending[0] is held at 0, so x0 never reads as busy.
   assign ra_busy_o = pending[ra_i];
   assign rb_busy_o = pending[rb_i];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_rd_o    <= '0;
         wr_value_o <= '0;
         pending    <= '0;
      end else begin
         pending <= pend_nxt;
         if (gnt_any) begin
            wr_rd_o    <= sel_rd;
            wr_value_o <= sel_value;
         end else begin
            wr_rd_o    <= '0;
            wr_value_o <= '0;
         end
      end
   end

endmodule

// File: doc/riscv_wb_sched.md
# riscv_wb_sched

Writeback scheduler for the rv32im core. It arbitrates result writes from several execution units (ALU, MUL, DIV, LSU) onto one registered register-file write port. It also keeps a pending-write scoreboard so issue logic can detect RAW hazards on source operands and WAW hazards on destinations. It sits between the execution units and write port 0 of `riscv_regfile`.

## Interface
- `NUM_SRC`, default 4: number of writeback requesters. Index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LSU.
- `clk_i` input 1: single clock; all state updates on its rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `req_valid_i` input NUM_SRC: per-source write request.
- `req_rd_i` input 5*NUM_SRC: per-source destination register; source k occupies bits [5k+4:5k].
- `req_value_i` input 32*NUM_SRC: per-source result; source k occupies bits [32k+31:32k].
- `req_ready_o` output NUM_SRC: one-hot grant; a request is accepted when valid and ready are both high.
- `alloc_valid_i` input 1: issue stage reserves a destination register.
- `alloc_rd_i` input 5: register being reserved.
- `alloc_ready_o` output 1: reservation is accepted this cycle.
- `ra_i`, `rb_i` input 5 each: source-operand indices to check.
- `ra_busy_o`, `rb_busy_o` output 1 each: operand has a pending write.
- `wr_rd_o` output 5: registered write index to the regfile; 0 means no write.
- `wr_value_o` output 32: registered write data.

## Operation
- **Arbitration:**
  - Each cycle at most one requester is granted, chosen among sources with `req_valid_i` high.
  - `req_ready_o` is combinational from `req_valid_i` and the arbiter state.
  - No grant is issued when no source is valid.
  - A source keeps valid, rd and value stable until it is accepted.
- **Write port:**
  - On acceptance, `wr_rd_o`/`wr_value_o` load the granted rd/value at the next edge.
  - With no acceptance they load 0 / 32'h0, so every write lasts exactly one cycle.
  - A request with rd = 0 is accepted normally and produces `wr_rd_o` = 0, i.e. no write.
- **Scoreboard (31 pending bits for x1..x31; x0 is never pending):**
  - `alloc_ready_o` = `alloc_valid_i` && (`alloc_rd_i` == 0 || !pending[`alloc_rd_i`]). A WAW reservation on a pending register is refused.
  - An accepted allocation with rd != 0 sets pending[rd] at the edge.
  - A nonzero `wr_rd_o` clears pending[`wr_rd_o`] at the edge that writes the regfile.
  - If a set and a clear target the same register in one cycle, the set wins.
  - `ra_busy_o` = pending[`ra_i`] and `rb_busy_o` = pending[`rb_i`], both combinational; index 0 always gives 0.
- **Writes to unreserved registers:** a writeback whose rd is not pending is still performed, and the clear has no effect.
- **Reset (`rst_i` low at an edge):**
  - `wr_rd_o` = 0, `wr_value_o` = 0.
  - All pending bits = 0 and the round-robin pointer = 0.
  - Any in-flight grant in that cycle is discarded.
  - `req_ready_o`, `alloc_ready_o` and the busy outputs are combinational and follow the cleared state from the next cycle.

## Timing
- Request accepted in cycle N → `wr_rd_o`/`wr_value_o` valid in cycle N+1 → regfile updated at the end of N+1.
- Pending bit cleared at the end of N+1 → busy low in N+2, when the regfile already holds the value. No bypass path is required.
- Allocation accepted in cycle N → busy high from N+1.
- Peak throughput is one writeback per cycle.

## Configuration
- `RISCV_WB_RR_EN` defined: round-robin arbitration.
  - A pointer holds the highest-priority index and advances to (granted index + 1) mod NUM_SRC after each grant.
  - The pointer holds when there is no grant.
- Macro undefined: fixed priority, lowest index wins (ALU > MUL > DIV > LSU). The pointer register is not built.

## Structure
- Shared package `riscv_pkg` holds:
  - `NUM_WB_SRC`.
  - Source index constants `WB_SRC_ALU`, `WB_SRC_MUL`, `WB_SRC_DIV`, `WB_SRC_LSU`.
  - The 5-bit register index width.
- Sub-module `riscv_wb_arb`: a pure grant generator covering both the fixed and round-robin variants. The scoreboard and output registers stay in the top module.

## Test plan
- **Reset:** hold `rst_i` low for 2 cycles with all sources valid → `wr_rd_o` = 0, all busy = 0, no write in the reset cycles.
- **Single writeback:** ALU writes rd = 5, value 32'hDEAD_BEEF in cycle N → `wr_rd_o` = 5, `wr_value_o` = 32'hDEAD_BEEF in N+1 only, and `wr_rd_o` = 0 in N+2.
- **Contention:** all 4 sources valid continuously with rd = 1..4.
  - `RISCV_WB_RR_EN` defined → grant order 0, 1, 2, 3, 0.
  - Macro undefined → source 0 is granted every cycle.
- **Scoreboard lifecycle:** alloc rd = 7 → `ra_i` = 7 gives `ra_busy_o` = 1; a second alloc of rd = 7 gets `alloc_ready_o` = 0; LSU writeback to rd = 7 → `ra_busy_o` = 0 two cycles after acceptance.
- **Same-cycle set and clear:** `wr_rd_o` = 9 while alloc rd = 9 is accepted → pending[9] stays 1.
- **x0 handling:** alloc rd = 0 and a request with rd = 0 → `alloc_ready_o` = 1, no pending bit set, request accepted, `wr_rd_o` stays 0.
